wb_write_buffer: RTL and testbench

In-order write buffer between the CPU's result producers and the register file write port. It accepts (destination index, result) pairs over a valid/ready handshake and queues them in a small FIFO. Each cycle the write port is granted, it drains the oldest entry into the register file. It also lets the decode stage's two source-register reads see results that are still queued (youngest match wins), so operands are never stale while writes wait for the port.

---
 rtl/wb_write_buffer_if.sv | 46 ++++
 rtl/wb_write_buffer.sv | 106 ++++++++++
 tb/tb_wb_write_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_buffer_if.sv
// Bus bundle for the register-file write buffer: producer handshake,
// write-port drain, decode-stage forwarding lookups and occupancy status.
interface wb_write_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Producer side
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    // Register file write port
    logic              drain_en;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Decode-stage operand lookups
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic              ra_hit;
    logic [DATA_W-1:0] ra_fwd;
    logic              rb_hit;
    logic [DATA_W-1:0] rb_fwd;

    // Occupancy
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport master (
        output in_valid, in_addr, in_data, drain_en, ra_addr, rb_addr,
        input  in_ready, we, wr_addr, wr_data,
        input  ra_hit, ra_fwd, rb_hit, rb_fwd, count, full, empty
    );

    modport slave (
        input  in_valid, in_addr, in_data, drain_en, ra_addr, rb_addr,
        output in_ready, we, wr_addr, wr_data,
        output ra_hit, ra_fwd, rb_hit, rb_fwd, count, full, empty
    );
endinterface

// File: rtl/wb_write_buffer.sv
// In-order write buffer in front of the register file write port.
// Results queue in a circular FIFO and drain oldest-first whenever the
// write port is granted; queued results are forwarded to the two decode
// read ports so operands are never stale while writes wait.
module wb_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_write_buffer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic full_w;
    logic empty_w;
    logic push_w;
    logic pop_w;

    // Status comes from the registered count only, so in_ready never
    // depends on drain_en in the same cycle (no full-cycle bypass).
    assign full_w  = (count_reg == CNT_W'(DEPTH));
    assign empty_w = (count_reg == '0);
    assign push_w  = bus.in_valid && !full_w;
    assign pop_w   = bus.drain_en && !empty_w;

    assign bus.in_ready = !full_w;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_reg;
    assign bus.we       = pop_w;
    assign bus.wr_addr  = addr_mem[head_reg];
    assign bus.wr_data  = data_mem[head_reg];

    // Entry storage: clear everything on reset, write the tail slot on a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (push_w) begin
            addr_mem[tail_reg] <= bus.in_addr;
            data_mem[tail_reg] <= bus.in_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_w) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop_w) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            case ({push_w, pop_w})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // One lookup per read port. Entries are scanned oldest to youngest by
    // logical age (head + k), so the last match is the youngest one and
    // physical wrap position never affects priority. The head entry being
    // drained this cycle is still scanned: it is not in the register file yet.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [ADDR_W-1:0] look_addr;
        logic              hit_w;
        logic [DATA_W-1:0] fwd_w;

        assign look_addr = (gi == 0) ? bus.ra_addr : bus.rb_addr;

        // Youngest occupied entry matching this port's index wins.
        always_comb begin
            hit_w = 1'b0;
            fwd_w = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if ((CNT_W'(k) < count_reg) &&
                    (addr_mem[head_reg + PTR_W'(k)] == look_addr)) begin
                    hit_w = 1'b1;
                    fwd_w = data_mem[head_reg + PTR_W'(k)];
                end
            end
        end
    end

    assign bus.ra_hit = g_fwd[0].hit_w;
    assign bus.ra_fwd = g_fwd[0].fwd_w;
    assign bus.rb_hit = g_fwd[1].hit_w;
    assign bus.rb_fwd = g_fwd[1].fwd_w;
endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer: a queue model scores every
// cycle, directed vector tables pin the documented sequences, and short
// hand-written sequences cover reset, concurrent push/pop and random traffic.
module tb_wb_write_buffer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } entry_t;

    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              dr;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_wa;
        logic [DATA_W-1:0] exp_wd;
        logic [2:0]        exp_cnt;
        logic              exp_rdy;
        logic              exp_rhit;
        logic [DATA_W-1:0] exp_rfwd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    entry_t sb[$];
    vec_t   tbl[$];

    wb_write_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference lookup: youngest queued entry with a matching index.
    task automatic model_fwd(input logic [ADDR_W-1:0] ra, output logic hit, output logic [DATA_W-1:0] val);
        hit = 1'b0;
        val = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].a == ra) begin
                hit = 1'b1;
                val = sb[i].d;
                break;
            end
        end
    endtask

    // Compare every output against the queue model, then apply this cycle's
    // pop/push to the model (the DUT commits them on the coming edge).
    task automatic model_check();
        int n;
        logic exp_rdy;
        logic exp_we;
        logic h;
        logic [DATA_W-1:0] f;
        entry_t e;
        n = sb.size();
        exp_rdy = (n < DEPTH);
        exp_we  = bus.drain_en && (n > 0);
        chk("count", 32'(bus.count), 32'(n));
        chk("full", 32'(bus.full), 32'(n == DEPTH));
        chk("empty", 32'(bus.empty), 32'(n == 0));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("we", 32'(bus.we), 32'(exp_we));
        if (exp_we) begin
            chk("wr_addr", 32'(bus.wr_addr), 32'(sb[0].a));
            chk("wr_data", 32'(bus.wr_data), 32'(sb[0].d));
        end
        model_fwd(bus.ra_addr, h, f);
        chk("ra_hit", 32'(bus.ra_hit), 32'(h));
        chk("ra_fwd", 32'(bus.ra_fwd), 32'(f));
        model_fwd(bus.rb_addr, h, f);
        chk("rb_hit", 32'(bus.rb_hit), 32'(h));
        chk("rb_fwd", 32'(bus.rb_fwd), 32'(f));
        if (exp_we) begin
            e = sb.pop_front();
            $display("cycle %0t: write r%0d = 0x%04h", $time, e.a, e.d);
        end
        if (bus.in_valid && exp_rdy) begin
            e.a = bus.in_addr;
            e.d = bus.in_data;
            sb.push_back(e);
            $display("cycle %0t: accept r%0d = 0x%04h", $time, e.a, e.d);
        end
    endtask

    task automatic cyc(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic dr, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.drain_en = dr;
        bus.ra_addr  = ra;
        bus.rb_addr  = rb;
        #1;
        model_check();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
        chk({tag, "_full"}, 32'(bus.full), 32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_we"}, 32'(bus.we), 32'd0);
        chk({tag, "_ra_hit"}, 32'(bus.ra_hit), 32'd0);
        chk({tag, "_ra_fwd"}, 32'(bus.ra_fwd), 32'd0);
        chk({tag, "_rb_hit"}, 32'(bus.rb_hit), 32'd0);
        chk({tag, "_rb_fwd"}, 32'(bus.rb_fwd), 32'd0);
    endtask

    initial begin
        logic              v;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                guard;

        checks = 0;
        passes = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.drain_en = 1'b1;
        bus.ra_addr  = '0;
        bus.rb_addr  = '0;

        // Fill/stall/drain (ra=1, rb=4), forwarding priority (ra=3, rb=6),
        // same-cycle input not forwarded (ra=rb=7).
        tbl.push_back('{1, 1, 16'h1111, 0, 1, 4,  0, 0, 16'h0000, 0, 1, 0, 16'h0000});
        tbl.push_back('{1, 2, 16'h2222, 0, 1, 4,  0, 0, 16'h0000, 1, 1, 1, 16'h1111});
        tbl.push_back('{1, 3, 16'h3333, 0, 1, 4,  0, 0, 16'h0000, 2, 1, 1, 16'h1111});
        tbl.push_back('{1, 4, 16'h4444, 0, 1, 4,  0, 0, 16'h0000, 3, 1, 1, 16'h1111});
        tbl.push_back('{1, 5, 16'h5555, 0, 1, 4,  0, 0, 16'h0000, 4, 0, 1, 16'h1111});
        tbl.push_back('{1, 5, 16'h5555, 0, 1, 4,  0, 0, 16'h0000, 4, 0, 1, 16'h1111});
        tbl.push_back('{1, 5, 16'h5555, 1, 1, 4,  1, 1, 16'h1111, 4, 0, 1, 16'h1111});
        tbl.push_back('{1, 5, 16'h5555, 1, 1, 4,  1, 2, 16'h2222, 3, 1, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 1, 4,  1, 3, 16'h3333, 3, 1, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 1, 4,  1, 4, 16'h4444, 2, 1, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 1, 4,  1, 5, 16'h5555, 1, 1, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 1, 4,  0, 0, 16'h0000, 0, 1, 0, 16'h0000});
        tbl.push_back('{1, 3, 16'h00AA, 0, 3, 6,  0, 0, 16'h0000, 0, 1, 0, 16'h0000});
        tbl.push_back('{1, 3, 16'h00BB, 0, 3, 6,  0, 0, 16'h0000, 1, 1, 1, 16'h00AA});
        tbl.push_back('{0, 0, 16'h0000, 0, 3, 6,  0, 0, 16'h0000, 2, 1, 1, 16'h00BB});
        tbl.push_back('{0, 0, 16'h0000, 1, 3, 6,  1, 3, 16'h00AA, 2, 1, 1, 16'h00BB});
        tbl.push_back('{0, 0, 16'h0000, 1, 3, 6,  1, 3, 16'h00BB, 1, 1, 1, 16'h00BB});
        tbl.push_back('{0, 0, 16'h0000, 0, 3, 6,  0, 0, 16'h0000, 0, 1, 0, 16'h0000});
        tbl.push_back('{1, 7, 16'hBEEF, 0, 7, 7,  0, 0, 16'h0000, 0, 1, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 0, 7, 7,  0, 0, 16'h0000, 1, 1, 1, 16'hBEEF});
        tbl.push_back('{0, 0, 16'h0000, 1, 7, 7,  1, 7, 16'hBEEF, 1, 1, 1, 16'hBEEF});
        tbl.push_back('{0, 0, 16'h0000, 0, 7, 7,  0, 0, 16'h0000, 0, 1, 0, 16'h0000});

        // Reset state, with drain_en high to show we stays low.
        #2;
        reset_checks("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].dr, tbl[i].ra, tbl[i].rb);
            chk($sformatf("vec%0d_we", i), 32'(bus.we), 32'(tbl[i].exp_we));
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_rdy));
            chk($sformatf("vec%0d_ra_hit", i), 32'(bus.ra_hit), 32'(tbl[i].exp_rhit));
            chk($sformatf("vec%0d_ra_fwd", i), 32'(bus.ra_fwd), 32'(tbl[i].exp_rfwd));
            if (tbl[i].exp_we) begin
                chk($sformatf("vec%0d_wr_addr", i), 32'(bus.wr_addr), 32'(tbl[i].exp_wa));
                chk($sformatf("vec%0d_wr_data", i), 32'(bus.wr_data), 32'(tbl[i].exp_wd));
            end
        end

        // Simultaneous push and pop at count 2, long enough to wrap pointers.
        cyc(1, 3'd2, 16'hA001, 0, 3'd2, 3'd6);
        cyc(1, 3'd6, 16'hA002, 0, 3'd2, 3'd6);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 3'($urandom_range(0, 7)), 16'($urandom), 1, 3'd2, 3'd6);
            chk("simul_count", 32'(bus.count), 32'd2);
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            cyc(0, 3'd0, 16'h0000, 1, 3'd2, 3'd6);
            guard++;
        end
        chk("simul_drained", 32'(sb.size()), 32'd0);

        // Random traffic; an offer refused while full is held unchanged.
        v = 1'b0;
        a = '0;
        d = '0;
        for (int i = 0; i < 200; i++) begin
            if (!(v && sb.size() == DEPTH)) begin
                v = 1'($urandom_range(0, 1));
                a = 3'($urandom_range(0, 7));
                d = 16'($urandom);
            end
            cyc(v, a, d, 1'($urandom_range(0, 2) != 0),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            cyc(0, 3'd0, 16'h0000, 1, 3'd0, 3'd1);
            guard++;
        end

        // Reset mid-run with three entries queued: nothing may be written.
        cyc(1, 3'd1, 16'hC001, 0, 3'd1, 3'd2);
        cyc(1, 3'd2, 16'hC002, 0, 3'd1, 3'd2);
        cyc(1, 3'd3, 16'hC003, 0, 3'd1, 3'd2);
        cyc(0, 3'd0, 16'h0000, 0, 3'd1, 3'd2);
        chk("pre_reset_count", 32'(bus.count), 32'd3);
        @(negedge clk);
        bus.drain_en = 1'b1;
        rst_n = 1'b0;
        #1;
        reset_checks("midreset");
        sb.delete();
        @(negedge clk);
        #1;
        reset_checks("midreset_hold");
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 3'd0, 16'h0000, 1, 3'd1, 3'd2);
        end
        cyc(1, 3'd5, 16'hD00D, 1, 3'd5, 3'd2);
        cyc(0, 3'd0, 16'h0000, 1, 3'd5, 3'd2);
        cyc(0, 3'd0, 16'h0000, 1, 3'd5, 3'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
